// File: rtl/mixer_sat_n.sv
// rtl/mixer_sat_n.sv - time-multiplexed N-voice saturating mixer with runtime attenuation
// Optional clip counter enabled by defining MIXER_CLIP_CNT_EN.
module mixer_sat_n #(
  parameter int DATA_W   = 24,
  parameter int N_VOICES = 10,
  parameter int GUARD_W  = 4,
  parameter int SHIFT_W  = 3,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              i_sync,
  input  logic [DATA_W-1:0] i_data,
  input  logic [SHIFT_W-1:0] i_shift,
  input  logic              i_mute,
  output logic [DATA_W-1:0] o_mixed,
  output logic              o_rdy,
  output logic              o_clip,
  output logic              o_resync,
  output logic [CNT_W-1:0]  o_clip_cnt
);

  localparam int ACC_W = DATA_W + GUARD_W;
  localparam int IDX_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(N_VOICES - 1);
  localparam logic [SHIFT_W-1:0]      MAX_SH   = SHIFT_W'(GUARD_W);
  localparam logic signed [ACC_W-1:0] SAT_MAX  = {{(GUARD_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN  = {{(GUARD_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [ACC_W-1:0] r_acc;
  logic [IDX_W-1:0]        r_v_idx;
  logic signed [ACC_W-1:0] w_ext;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_shifted;
  logic [SHIFT_W-1:0]      w_sh;
  logic [DATA_W-1:0]       w_sat;
  logic                    w_restart;
  logic                    w_last;
  logic                    w_over;
  logic                    w_under;
  logic                    w_clip;

  assign w_ext     = {{GUARD_W{i_data[DATA_W-1]}}, i_data};
  // With a single voice every sample is a whole frame, so i_sync never restarts.
  assign w_restart = clk_en && i_sync && (N_VOICES > 1);
  assign w_last    = clk_en && !w_restart && (r_v_idx == LAST_IDX);
  assign w_sum     = r_acc + w_ext;
  assign w_sh      = (i_shift > MAX_SH) ? MAX_SH : i_shift;
  assign w_shifted = w_sum >>> w_sh;
  assign w_over    = w_shifted > SAT_MAX;
  assign w_under   = w_shifted < SAT_MIN;
  assign w_sat     = w_over  ? {1'b0, {(DATA_W-1){1'b1}}} :
                     w_under ? {1'b1, {(DATA_W-1){1'b0}}} :
                               w_shifted[DATA_W-1:0];
  assign w_clip    = (w_over || w_under) && !i_mute;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_v_idx  <= '0;
      o_mixed  <= '0;
      o_rdy    <= 1'b0;
      o_clip   <= 1'b0;
      o_resync <= 1'b0;
    end else begin
      o_rdy    <= 1'b0;
      o_resync <= 1'b0;
      if (w_last) begin
        o_mixed <= i_mute ? '0 : w_sat;
        o_clip  <= w_clip;
        o_rdy   <= 1'b1;
        r_acc   <= '0;
        r_v_idx <= '0;
      end else if (w_restart) begin
        o_resync <= (r_v_idx != '0);
        r_acc    <= w_ext;
        r_v_idx  <= IDX_W'(1);
      end else if (clk_en) begin
        r_acc   <= w_sum;
        r_v_idx <= r_v_idx + IDX_W'(1);
      end
    end
  end

`ifdef MIXER_CLIP_CNT_EN
  logic [CNT_W-1:0] r_clip_cnt;

  // Counts alongside the o_rdy/o_clip update so the new count is visible with the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clip_cnt <= '0;
    end else if (w_last && w_clip && (r_clip_cnt != '1)) begin
      r_clip_cnt <= r_clip_cnt + CNT_W'(1);
    end
  end

  assign o_clip_cnt = r_clip_cnt;
`else
  assign o_clip_cnt = '0;
`endif

endmodule

// File: tb/tb_mixer_sat_n.sv
// tb/tb_mixer_sat_n.sv - scoreboard bench for mixer_sat_n
module tb_mixer_sat_n;
  localparam int DATA_W = 24;
  localparam int N_V    = 10;
  localparam int GUARD  = 4;
  localparam int SHW    = 3;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clk_en = 1'b0;
  logic              i_sync = 1'b0;
  logic [DATA_W-1:0] i_data = '0;
  logic [SHW-1:0]    i_shift = '0;
  logic              i_mute = 1'b0;
  logic [DATA_W-1:0] o_mixed;
  logic              o_rdy;
  logic              o_clip;
  logic              o_resync;
  logic [CNT_W-1:0]  o_clip_cnt;

  typedef struct {
    logic [DATA_W-1:0] mixed;
    logic              clip;
    logic [CNT_W-1:0]  cnt;
  } exp_t;

  exp_t    sb[$];
  int      n_cmp = 0;
  int      n_bad = 0;
  int      n_rdy = 0;
  longint  m_acc = 0;
  int      m_idx = 0;
  int      m_cnt = 0;

  mixer_sat_n #(.DATA_W(DATA_W), .N_VOICES(N_V), .GUARD_W(GUARD), .SHIFT_W(SHW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .i_sync(i_sync), .i_data(i_data),
    .i_shift(i_shift), .i_mute(i_mute), .o_mixed(o_mixed), .o_rdy(o_rdy),
    .o_clip(o_clip), .o_resync(o_resync), .o_clip_cnt(o_clip_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; the frame-end expectation is pushed before the accepting edge.
  task automatic step(input logic en, input logic sync, input longint d,
                      input int sh, input logic mute);
    logic   exp_resync;
    longint sum, s, sat;
    int     sh_eff;
    exp_t   e;
    exp_resync = 1'b0;
    clk_en  = en;
    i_sync  = sync;
    i_data  = DATA_W'(d);
    i_shift = SHW'(sh);
    i_mute  = mute;
    if (en) begin
      if (sync) begin
        exp_resync = (m_idx != 0);
        m_acc = d;
        m_idx = 1;
      end else if (m_idx == N_V - 1) begin
        sum    = m_acc + d;
        sh_eff = (sh > GUARD) ? GUARD : sh;
        s      = sum >>> sh_eff;
        sat    = (s > 64'sd8388607) ? 64'sd8388607 : (s < -64'sd8388608) ? -64'sd8388608 : s;
        e.mixed = mute ? '0 : DATA_W'(sat);
        e.clip  = (s != sat) && !mute;
`ifdef MIXER_CLIP_CNT_EN
        if (e.clip && m_cnt < 65535) m_cnt++;
`endif
        e.cnt = CNT_W'(m_cnt);
        sb.push_back(e);
        m_acc = 0;
        m_idx = 0;
      end else begin
        m_acc = m_acc + d;
        m_idx++;
      end
    end
    @(posedge clk);
    #1;
    chk("o_resync", 32'(o_resync), 32'(exp_resync));
  endtask

  task automatic frame(input longint d, input int sh, input logic mute);
    for (int k = 0; k < N_V; k++) step(1'b1, 1'b0, d, sh, mute);
    step(1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && o_rdy) begin
      n_rdy++;
      if (sb.size() == 0) begin
        chk("unexpected_o_rdy", 32'(o_rdy), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("o_mixed", 32'(o_mixed), 32'(e.mixed));
        chk("o_clip", 32'(o_clip), 32'(e.clip));
        chk("o_clip_cnt", 32'(o_clip_cnt), 32'(e.cnt));
      end
    end
  end

  initial begin
    #3;
    chk("rst_o_mixed", 32'(o_mixed), 32'd0);
    chk("rst_o_rdy", 32'(o_rdy), 32'd0);
    chk("rst_o_clip", 32'(o_clip), 32'd0);
    chk("rst_o_resync", 32'(o_resync), 32'd0);
    chk("rst_o_clip_cnt", 32'(o_clip_cnt), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    frame(100, 0, 1'b0);
    chk("sum_1000", 32'(o_mixed), 32'd1000);
    frame(64'sh7FFFFF, 0, 1'b0);
    chk("pos_sat", 32'(o_mixed), 32'h7FFFFF);
    frame(64'sh7FFFFF, 4, 1'b0);
    chk("shift4", 32'(o_mixed), 32'd5242879);
    frame(64'sh7FFFFF, 7, 1'b0);
    chk("shift7_clamped", 32'(o_mixed), 32'd5242879);
    frame(-8388608, 0, 1'b0);
    chk("neg_sat", 32'(o_mixed), 32'h800000);
    frame(0, 0, 1'b0);
    chk("acc_cleared", 32'(o_mixed), 32'd0);
    frame(-1, 4, 1'b0);
    chk("floor_shift", 32'(o_mixed), 32'hFFFFFF);
    frame(64'sh7FFFFF, 0, 1'b1);
    chk("mute", 32'(o_mixed), 32'd0);

    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 50, 0, 1'b0);
    step(1'b1, 1'b1, 7, 0, 1'b0);
    for (int k = 0; k < 9; k++) step(1'b1, 1'b0, 1, 0, 1'b0);
    step(1'b0, 1'b0, 0, 0, 1'b0);
    chk("resync_sum", 32'(o_mixed), 32'd16);

    step(1'b1, 1'b1, 5, 2, 1'b0);
    for (int k = 0; k < 9; k++) step(1'b1, 1'b0, 5, 2, 1'b0);
    step(1'b0, 1'b0, 0, 0, 1'b0);

    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 9, 0, 1'b0);
    rst = 1'b1;
    #2;
    chk("midrst_o_mixed", 32'(o_mixed), 32'd0);
    chk("midrst_o_clip_cnt", 32'(o_clip_cnt), 32'd0);
    rst = 1'b0;
    m_acc = 0;
    m_idx = 0;
    m_cnt = 0;
    for (int k = 0; k < N_V; k++) begin
      step(1'b1, 1'b0, 3, 0, 1'b0);
      if (k % 3 == 1) step(1'b0, 1'b0, 77, 0, 1'b0);
    end
    step(1'b0, 1'b0, 0, 0, 1'b0);
    chk("after_rst_30", 32'(o_mixed), 32'd30);

    repeat (3) step(1'b0, 1'b0, 0, 0, 1'b0);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    chk("rdy_count", 32'(n_rdy), 32'd11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
